// File: rtl/seq_detector_if.sv
// Bit-stream bundle between the flip-flop stage and the pattern detector.
//   din       : serial data bit (q of the upstream flop)
//   din_vld   : din qualifier, bit is consumed only when high
//   match     : registered one-cycle hit pulse
//   match_cnt : saturating hit count since reset
//   hist      : current shift history, MSB is the oldest bit
// master = bit-stream producer / status consumer, slave = detector.
interface seq_detector_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               din;
  logic               din_vld;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic [PAT_LEN-1:0] hist;

  modport master (
    output din, din_vld,
    input  match, match_cnt, hist
  );

  modport slave (
    input  din, din_vld,
    output match, match_cnt, hist
  );
endinterface

// File: rtl/seq_detector.sv
// Serial pattern detector for the registered q stream of the flip-flop stage.
// Flags every occurrence of a PAT_LEN-bit PATTERN (MSB = oldest bit) in the
// valid-qualified bit stream and keeps a saturating hit count.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high, overrides din_vld
//   bus : seq_detector_if slave (din, din_vld in; match, match_cnt, hist out)
// Parameters:
//   PAT_LEN : pattern length, 2..32
//   PATTERN : target pattern, must fit in PAT_LEN bits
//   OVERLAP : 1 = hits may share trailing bits, 0 = history restarts after a hit
//   CNT_W   : match counter width
module seq_detector #(
  parameter int unsigned PAT_LEN = 4,
  parameter logic [31:0] PATTERN = 32'b1011,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_detector_if.slave bus
);

  // Fill counter needs to represent 0..PAT_LEN inclusive.
  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  generate
    if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
      $error("seq_detector: PAT_LEN must be in 2..32");
    end
    if ((PATTERN >> PAT_LEN) != 32'd0) begin : g_bad_pattern
      $error("seq_detector: PATTERN is wider than PAT_LEN");
    end
    if (CNT_W < 1) begin : g_bad_cnt
      $error("seq_detector: CNT_W must be at least 1");
    end
  endgenerate

  logic [PAT_LEN-1:0] hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic               match_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [PAT_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               hit;

  // Next-state view assuming the current bit is accepted; only used when
  // din_vld is high, so din never reaches match without a register between.
  always_comb begin
    hist_n = {hist_q[PAT_LEN-2:0], bus.din};
    fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    // Requiring a full fill keeps reset zeros in hist from ever matching.
    hit    = (fill_n == FILL_FULL) && (hist_n == PATTERN[PAT_LEN-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.din_vld) begin
      hist_q  <= hist_n;
      match_q <= hit;
      // Without overlap the history bits stay visible but no longer count.
      fill_q  <= (hit && !OVERLAP) ? '0 : fill_n;
      if (hit && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      match_q <= 1'b0;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.hist      = hist_q;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector. Four instances share one stimulus
// stream and differ in pattern, overlap mode and counter width; each is
// compared against a reference that keeps the list of accepted bits.
module tb_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_vld = 1'b0;

  always #5 clk = ~clk;

  // Per-instance configuration for the reference model.
  localparam int MPAT [4] = '{11, 11, 1, 11};
  localparam int MOV  [4] = '{1, 0, 1, 1};
  localparam int MCW  [4] = '{8, 8, 8, 2};
  localparam int L = 4;
  localparam int HMAX = 8192;

  seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if0 ();
  seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if1 ();
  seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) if2 ();
  seq_detector_if #(.PAT_LEN(4), .CNT_W(2)) if3 ();

  assign if0.din = din;  assign if0.din_vld = din_vld;
  assign if1.din = din;  assign if1.din_vld = din_vld;
  assign if2.din = din;  assign if2.din_vld = din_vld;
  assign if3.din = din;  assign if3.din_vld = din_vld;

  seq_detector #(.PAT_LEN(4), .PATTERN(32'b1011), .OVERLAP(1'b1), .CNT_W(8))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  seq_detector #(.PAT_LEN(4), .PATTERN(32'b1011), .OVERLAP(1'b0), .CNT_W(8))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  seq_detector #(.PAT_LEN(4), .PATTERN(32'b0001), .OVERLAP(1'b1), .CNT_W(8))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  seq_detector #(.PAT_LEN(4), .PATTERN(32'b1011), .OVERLAP(1'b1), .CNT_W(2))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  logic        got_m [4];
  logic [31:0] got_c [4];
  logic [31:0] got_h [4];

  assign got_m[0] = if0.match;  assign got_c[0] = 32'(if0.match_cnt);  assign got_h[0] = 32'(if0.hist);
  assign got_m[1] = if1.match;  assign got_c[1] = 32'(if1.match_cnt);  assign got_h[1] = 32'(if1.hist);
  assign got_m[2] = if2.match;  assign got_c[2] = 32'(if2.match_cnt);  assign got_h[2] = 32'(if2.hist);
  assign got_m[3] = if3.match;  assign got_c[3] = 32'(if3.match_cnt);  assign got_h[3] = 32'(if3.hist);

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every accepted bit since reset is kept in order; 'start' marks
  // the first bit that may still contribute to a hit (moved on non-overlap hits).
  bit hb [4][HMAX];
  int nb    [4];
  int start [4];
  int mcnt  [4];
  int mexp  [4];

  function automatic int tail(input int k);
    int v = 0;
    for (int i = 0; i < L; i++) begin
      int idx = nb[k] - 1 - i;
      if (idx >= 0 && hb[k][idx]) v += (1 << i);
    end
    return v;
  endfunction

  task automatic model_edge(input int k, input logic r, input logic d, input logic v);
    if (r) begin
      nb[k] = 0; start[k] = 0; mcnt[k] = 0; mexp[k] = 0;
    end else if (!v) begin
      mexp[k] = 0;
    end else begin
      if (nb[k] >= HMAX) begin
        $display("FAIL model_overflow got=%0d exp=<%0d", nb[k], HMAX);
        $fatal(1, "reference history overflow");
      end
      hb[k][nb[k]] = d;
      nb[k]++;
      mexp[k] = 0;
      if ((nb[k] - start[k] >= L) && (tail(k) == MPAT[k])) begin
        mexp[k] = 1;
        if (mcnt[k] < (1 << MCW[k]) - 1) mcnt[k]++;
        if (MOV[k] == 0) start[k] = nb[k];
      end
    end
  endtask

  task automatic step(input logic r, input logic d, input logic v);
    rst = r; din = d; din_vld = v;
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_edge(k, r, d, v);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("match%0d", k), 32'(got_m[k]), 32'(mexp[k]));
      chk($sformatf("cnt%0d", k),   got_c[k],      32'(mcnt[k]));
      chk($sformatf("hist%0d", k),  got_h[k],      32'(tail(k)));
    end
  endtask

  task automatic bits(input logic [15:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, b[i], 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      nb[k] = 0; start[k] = 0; mcnt[k] = 0; mexp[k] = 0;
    end

    // Reset overrides an active valid bit.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_match", 32'(got_m[0]), 32'd0);
    chk("rst_cnt",   got_c[0],      32'd0);
    chk("rst_hist",  got_h[0],      32'd0);

    // 1,0,1 no hit, then 1 completes 1011.
    bits(16'b101, 3);
    chk("t1_nohit", 32'(got_m[0]), 32'd0);
    bits(16'b1, 1);
    chk("t2_match", 32'(got_m[0]), 32'd1);
    chk("t2_cnt",   got_c[0],      32'd1);
    chk("t2_hist",  got_h[0],      32'b1011);
    step(1'b0, 1'b0, 1'b0);
    chk("t2_pulse_len", 32'(got_m[0]), 32'd0);

    // Continue with 0,1,1: overlap instance hits again, non-overlap does not.
    bits(16'b011, 3);
    chk("t3_ov_cnt",  got_c[0], 32'd2);
    chk("t3_nov_cnt", got_c[1], 32'd1);

    // Non-overlap: 1,0,1,1,1,0,1,1 gives two hits.
    step(1'b1, 1'b0, 1'b0);
    bits(16'b10111011, 8);
    chk("t3_nov_cnt2", got_c[1], 32'd2);

    // Valid gaps with din toggling while invalid.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] p = 4'b1011;
      step(1'b0, p[i], 1'b1);
      for (int g = 0; g < 3; g++) step(1'b0, g[0], 1'b0);
    end
    chk("t4_gap_cnt", got_c[0], 32'd1);

    // Startup guard for pattern 0001.
    step(1'b1, 1'b0, 1'b0);
    bits(16'b1, 1);
    chk("t5_guard", 32'(got_m[2]), 32'd0);
    bits(16'b0001, 4);
    chk("t5_match", 32'(got_m[2]), 32'd1);
    chk("t5_cnt",   got_c[2],      32'd1);

    // Saturation with a 2-bit counter, then reset mid-pattern.
    step(1'b1, 1'b0, 1'b0);
    bits(16'b1011011011011011, 16);
    chk("t6_sat", got_c[3], 32'd3);
    bits(16'b101, 3);
    step(1'b1, 1'b0, 1'b0);
    bits(16'b1, 1);
    chk("t6_rst_match", 32'(got_m[3]), 32'd0);
    chk("t6_rst_cnt",   got_c[3],      32'd0);

    // Randomized stream with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      logic r = ($urandom_range(0, 199) == 0);
      logic d = $urandom_range(0, 1) == 1;
      logic v = ($urandom_range(0, 3) != 0);
      step(r, d, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
